// File: rtl/demux14_pack_pkg.sv
// Shared parameters, FSM state type and the key one-hot helper for the
// slice-packing demultiplexer.
package demux14_pack_pkg;

    localparam int NR_KEY   = 4;
    localparam int KEY_LEN  = 2;
    localparam int DATA_LEN = 2;
    localparam int WORD_LEN = NR_KEY * DATA_LEN;

    // Mask value meaning every lane of the word has been written
    localparam logic [NR_KEY-1:0] MASK_FULL = {NR_KEY{1'b1}};

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    // One-hot lane select for a key; key is used zero-extended as the index
    function automatic logic [NR_KEY-1:0] onehot(input logic [KEY_LEN-1:0] key);
        logic [NR_KEY-1:0] oh;
        oh      = {NR_KEY{1'b0}};
        oh[key] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux14_pack_if.sv
// Slice-in / word-out handshake bundle for demux14_pack.
interface demux14_pack_if;
    import demux14_pack_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [KEY_LEN-1:0]  in_key;
    logic [DATA_LEN-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [WORD_LEN-1:0] out_word;
    logic                dup_err;

    // Design side: consumes slices, produces packed words
    modport slave (
        input  in_valid, in_key, in_data, out_ready,
        output in_ready, out_valid, out_word, dup_err
    );

    // Environment side: issues slices, drains packed words
    modport master (
        output in_valid, in_key, in_data, out_ready,
        input  in_ready, out_valid, out_word, dup_err
    );
endinterface

// File: rtl/demux14_pack_key_decoder.sv
// Key to one-hot lane write-enable decoder; the same enables also update
// the written-lane mask.
module demux14_pack_key_decoder
    import demux14_pack_pkg::*;
(
    input  logic [KEY_LEN-1:0] key_i,
    input  logic               en_i,
    output logic [NR_KEY-1:0]  lane_we_o
);

    // Enable exactly one lane when a slice is being accepted, none otherwise
    always_comb begin
        lane_we_o = {NR_KEY{1'b0}};
        if (en_i) begin
            lane_we_o = onehot(key_i);
        end else begin
            lane_we_o = {NR_KEY{1'b0}};
        end
    end

endmodule

// File: rtl/demux14_pack.sv
// Packs DATA_LEN-bit slices, addressed by key, into an NR_KEY-lane word and
// hands the word downstream once every lane has been written. A slice may be
// accepted in the same cycle the previous word drains, so a continuous stream
// needs no bubbles.
module demux14_pack
    import demux14_pack_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    demux14_pack_if.slave  bus
);

    state_e              state_q, state_d;
    logic [WORD_LEN-1:0] word_q, word_d;
    logic [NR_KEY-1:0]   mask_q, mask_d;
    logic                dup_err_q, dup_err_d;

    logic                in_ready_s;
    logic                accept_s;
    logic                drain_s;
    logic [NR_KEY-1:0]   lane_we_s;
    logic [WORD_LEN-1:0] base_word_s;
    logic [NR_KEY-1:0]   base_mask_s;

    // Input is open while filling; when full, only if the word leaves this cycle
    always_comb begin
        in_ready_s = 1'b0;
        case (state_q)
            ST_FILL: in_ready_s = 1'b1;
            ST_FULL: in_ready_s = bus.out_ready;
            default: in_ready_s = 1'b0;
        endcase
    end

    assign accept_s = bus.in_valid & in_ready_s;
    assign drain_s  = (state_q == ST_FULL) & bus.out_ready;

    demux14_pack_key_decoder u_key_decoder (
        .key_i     (bus.in_key),
        .en_i      (accept_s),
        .lane_we_o (lane_we_s)
    );

    // Next word/mask/state: a draining word is cleared before the new slice lands
    always_comb begin
        base_word_s = word_q;
        base_mask_s = mask_q;
        if (drain_s) begin
            base_word_s = {WORD_LEN{1'b0}};
            base_mask_s = {NR_KEY{1'b0}};
        end else begin
            base_word_s = word_q;
            base_mask_s = mask_q;
        end

        word_d = base_word_s;
        for (int k = 0; k < NR_KEY; k++) begin
            if (lane_we_s[k]) begin
                word_d[k*DATA_LEN +: DATA_LEN] = bus.in_data;
            end else begin
                word_d[k*DATA_LEN +: DATA_LEN] = base_word_s[k*DATA_LEN +: DATA_LEN];
            end
        end

        mask_d    = base_mask_s | lane_we_s;
        // After a drain the base mask is empty, so no duplicate can be flagged in FULL
        dup_err_d = |(base_mask_s & lane_we_s);

        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (mask_d == MASK_FULL) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_FULL: begin
                if (drain_s && (mask_d != MASK_FULL)) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Datapath and FSM registers; reset discards any partially packed word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FILL;
            word_q    <= {WORD_LEN{1'b0}};
            mask_q    <= {NR_KEY{1'b0}};
            dup_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            mask_q    <= mask_d;
            dup_err_q <= dup_err_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_word  = word_q;
    assign bus.dup_err   = dup_err_q;

endmodule

// File: tb/tb_demux14_pack.sv
// Directed bench for demux14_pack: the driver pushes hand-computed expected
// words into a queue, a separate monitor pops and compares on each handshake.
module tb_demux14_pack;
    import demux14_pack_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    demux14_pack_if bus ();

    demux14_pack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int dup_seen = 0;
    int bubbles = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each drained word against the scoreboard, count dup pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {24'h0, bus.out_word}, 32'hFFFF_FFFF);
                end else begin
                    check("out_word", {24'h0, bus.out_word}, {24'h0, exp_q.pop_front()});
                end
            end
            if (bus.dup_err) dup_seen++;
        end
    end

    // Present one slice and hold it until accepted (bounded)
    task automatic send(input logic [1:0] k, input logic [1:0] d);
        logic rdy;
        int   n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_key   = k;
        bus.in_data  = d;
        do begin
            @(negedge clk);
            rdy = bus.in_ready;
            if (!rdy) bubbles++;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int cycles);
        bus.in_valid = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_key    = 2'd0;
        bus.in_data   = 2'd0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
        check("rst_out_word", {24'h0, bus.out_word}, 32'h0);
        check("rst_dup_err", {31'h0, bus.dup_err}, 32'd0);
        check("rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: in-order lanes, latency and single-cycle valid
        exp_q.push_back(8'h39);
        send(2'd0, 2'b01);
        send(2'd1, 2'b10);
        send(2'd2, 2'b11);
        check("t1_valid_before_last", {31'h0, bus.out_valid}, 32'd0);
        send(2'd3, 2'b00);
        check("t1_valid_after_last", {31'h0, bus.out_valid}, 32'd1);
        idle(1);
        check("t1_valid_one_cycle", {31'h0, bus.out_valid}, 32'd0);

        // 2: permuted lane order
        exp_q.push_back(8'hFF);
        send(2'd3, 2'b11);
        send(2'd1, 2'b11);
        send(2'd0, 2'b11);
        send(2'd2, 2'b11);
        idle(2);

        // 3: duplicate key overwrites lane 0 and flags dup_err once
        exp_q.push_back(8'h02);
        send(2'd0, 2'b01);
        send(2'd0, 2'b10);
        send(2'd1, 2'b00);
        send(2'd2, 2'b00);
        send(2'd3, 2'b00);
        idle(2);
        check("t3_dup_count", dup_seen, 32'd1);

        // 4: backpressure holds the word, then drain with simultaneous accept
        exp_q.push_back(8'h55);
        bus.out_ready = 1'b0;
        send(2'd0, 2'b01);
        send(2'd1, 2'b01);
        send(2'd2, 2'b01);
        send(2'd3, 2'b01);
        bus.in_valid = 1'b1;
        bus.in_key   = 2'd2;
        bus.in_data  = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_in_ready_held", {31'h0, bus.in_ready}, 32'd0);
            check("t4_word_stable", {24'h0, bus.out_word}, 32'h55);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        exp_q.push_back(8'h30);
        send(2'd2, 2'b11);
        check("t4_fill_after_drain", {31'h0, bus.out_valid}, 32'd0);
        check("t4_word_after_drain", {24'h0, bus.out_word}, 32'h30);
        send(2'd0, 2'b00);
        send(2'd1, 2'b00);
        check("t4_not_full_early", {31'h0, bus.out_valid}, 32'd0);
        send(2'd3, 2'b00);
        idle(2);

        // 5: reset mid-word discards the partial word
        send(2'd0, 2'b11);
        send(2'd1, 2'b11);
        send(2'd2, 2'b11);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_rst_word", {24'h0, bus.out_word}, 32'h0);
        @(posedge clk);
        #1;
        check("t5_no_valid", {31'h0, bus.out_valid}, 32'd0);
        exp_q.push_back(8'h06);
        send(2'd3, 2'b00);
        send(2'd2, 2'b00);
        send(2'd1, 2'b01);
        check("t5_no_spurious", {31'h0, bus.out_valid}, 32'd0);
        send(2'd0, 2'b10);
        idle(2);

        // 6: twelve slices back to back, no bubbles
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h99);
        exp_q.push_back(8'hC3);
        bubbles = 0;
        send(2'd0, 2'd3); send(2'd1, 2'd2); send(2'd2, 2'd1); send(2'd3, 2'd0);
        send(2'd2, 2'd1); send(2'd0, 2'd1); send(2'd3, 2'd2); send(2'd1, 2'd2);
        send(2'd1, 2'd0); send(2'd3, 2'd3); send(2'd0, 2'd3); send(2'd2, 2'd0);
        check("t6_bubbles", bubbles, 32'd0);
        idle(1);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("dup_total", dup_seen, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
